// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: holds the active divisor,
// swaps in new divisors only at period boundaries, and sequences whole-period start/stop.
module clk_div_ctrl #(
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(5)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_divisor,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             clock_out,
  output logic             tick,
  output logic             running,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] div_active;
  logic [WIDTH-1:0] div_pend;
  logic             pend_flag;
  logic             wrap;
  logic             accept;
  logic             div_ok;

  // Handshake: a divisor transfers on any edge where cfg_valid && cfg_ready.
  // cfg_ready drops while a divisor waits for the next period boundary.
  assign cfg_ready = !pend_flag;
  assign accept    = cfg_valid && cfg_ready;
  assign div_ok    = cfg_divisor >= WIDTH'(2);
  assign wrap      = (state != IDLE) && (counter == div_active - WIDTH'(1));

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN keeps counting so the last period completes; start cancels the drain.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN:     if (stop && !start) state_next = DRAIN;
      DRAIN: begin
        if (start)     state_next = RUN;
        else if (wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running   = (state != IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      div_active <= DEFAULT_DIV;
      div_pend   <= DEFAULT_DIV;
      pend_flag  <= 1'b0;
      clock_out  <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      clock_out <= (state != IDLE) && (counter < (div_active >> 1));
      tick      <= wrap;
      cfg_err   <= accept && !div_ok;

      if (state == IDLE || wrap) begin
        counter <= '0;
      end else begin
        counter <= counter + WIDTH'(1);
      end

      // A pending divisor blocks new transfers, so the two branches never compete.
      if (wrap && pend_flag) begin
        div_active <= div_pend;
        pend_flag  <= 1'b0;
      end else if (accept && div_ok) begin
        if (state == IDLE) begin
          div_active <= cfg_divisor;
        end else begin
          div_pend  <= cfg_divisor;
          pend_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, every cycle compared
// against a period-level behavioural model of the divider controller.
module tb_clk_div_ctrl;
  localparam int WIDTH = 28;

  logic             clock_in = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_divisor;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic             clock_out;
  logic             tick;
  logic             running;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle / 1 run / 2 drain, position within the period,
  // the divisor in force and the divisor(s) awaiting a boundary.
  int     m_mode;
  longint m_pos;
  longint m_div;
  longint pend_q[$];
  logic   e_clk;
  logic   e_tick;
  logic   e_err;

  always #5 clock_in = ~clock_in;

  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(WIDTH'(5))) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_divisor (cfg_divisor),
    .cfg_err     (cfg_err),
    .start       (start),
    .stop        (stop),
    .clock_out   (clock_out),
    .tick        (tick),
    .running     (running),
    .state_dbg   (state_dbg)
  );

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pos  = 0;
    m_div  = 5;
    pend_q.delete();
    e_clk  = 1'b0;
    e_tick = 1'b0;
    e_err  = 1'b0;
  endtask

  // One clock edge of the controller, in terms of periods and positions.
  task automatic model_edge();
    bit acc;
    bit wrap;
    acc    = cfg_valid && (pend_q.size() == 0);
    wrap   = (m_mode != 0) && (m_pos == m_div - 1);
    e_clk  = (m_mode != 0) && (m_pos < m_div / 2);
    e_tick = wrap;
    e_err  = acc && (cfg_divisor < 2);
    if (wrap && pend_q.size() != 0) m_div = pend_q.pop_front();
    if (acc && cfg_divisor >= 2) begin
      if (m_mode == 0) m_div = longint'(cfg_divisor);
      else pend_q.push_back(longint'(cfg_divisor));
    end
    case (m_mode)
      0: if (start && !stop) m_mode = 1;
      1: begin
        m_pos = wrap ? 0 : m_pos + 1;
        if (stop && !start) m_mode = 2;
      end
      default: begin
        m_pos = wrap ? 0 : m_pos + 1;
        if (start) m_mode = 1;
        else if (wrap) m_mode = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check_bit("clock_out", clock_out, e_clk);
    check_bit("tick", tick, e_tick);
    check_bit("cfg_err", cfg_err, e_err);
    check_bit("cfg_ready", cfg_ready, pend_q.size() == 0);
    check_bit("running", running, m_mode != 0);
  endtask

  task automatic cyc();
    @(posedge clock_in);
    model_edge();
    @(negedge clock_in);
    compare_all();
  endtask

  // Leaves the current cycle, waits for a tick, then counts cycles to the next tick.
  task automatic measure_period(input string tag, input int expv);
    int n;
    n = 0;
    cyc();
    while (tick !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    check_bit({tag, "_wait"}, n < 100, 1'b1);
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 100);
    check_int(tag, n, expv);
  endtask

  bit pat5_clk[10]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  bit pat5_tick[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  bit pat4_clk[8]   = '{1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    int  n;
    bit  rdy;
    reset       = 1'b1;
    cfg_valid   = 1'b0;
    cfg_divisor = '0;
    start       = 1'b0;
    stop        = 1'b0;
    model_reset();
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    #1;
    compare_all();
    check_bit("reset_ready", cfg_ready, 1'b1);
    check_bit("reset_running", running, 1'b0);

    // Default divisor 5: H,H,L,L,L with tick at each wrap.
    @(negedge clock_in);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_bit("start_running", running, 1'b1);
    check_bit("start_no_tick", tick, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_bit("pat5_clk", clock_out, pat5_clk[i]);
      check_bit("pat5_tick", tick, pat5_tick[i]);
    end

    // Divisor 4 written mid-period takes effect at the wrap.
    cyc();
    cfg_valid   = 1'b1;
    cfg_divisor = WIDTH'(4);
    cyc();
    cfg_valid = 1'b0;
    check_bit("pend_ready_low", cfg_ready, 1'b0);
    cyc();
    cyc();
    check_bit("pend_ready_still_low", cfg_ready, 1'b0);
    cyc();
    check_bit("pend_wrap_tick", tick, 1'b1);
    check_bit("pend_wrap_ready", cfg_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_bit("pat4_clk", clock_out, pat4_clk[i]);
    end

    // Back-to-back writes: second one stalls until the first is consumed.
    cfg_valid   = 1'b1;
    cfg_divisor = WIDTH'(4);
    cyc();
    cfg_divisor = WIDTH'(6);
    n = 0;
    do begin
      rdy = cfg_ready;
      cyc();
      n++;
    end while (!rdy && n < 20);
    cfg_valid = 1'b0;
    check_int("b2b_stall", n, 4);
    measure_period("b2b_period6", 6);

    // Divisors below 2 are rejected with a one-cycle error pulse.
    cfg_valid   = 1'b1;
    cfg_divisor = WIDTH'(1);
    cyc();
    check_bit("err_div1", cfg_err, 1'b1);
    cfg_divisor = WIDTH'(0);
    cyc();
    check_bit("err_div0", cfg_err, 1'b1);
    cfg_valid = 1'b0;
    cyc();
    check_bit("err_clear", cfg_err, 1'b0);
    measure_period("err_period_kept", 6);

    // Back to divisor 5, then stop at position 1: the period completes.
    cfg_valid   = 1'b1;
    cfg_divisor = WIDTH'(5);
    cyc();
    cfg_valid = 1'b0;
    measure_period("restore5", 5);
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    cyc();
    check_bit("drain_running", running, 1'b1);
    cyc();
    check_bit("drain_done_running", running, 1'b0);
    check_bit("drain_final_tick", tick, 1'b1);
    check_bit("drain_done_clk", clock_out, 1'b0);
    cyc();
    check_bit("idle_clk", clock_out, 1'b0);

    // Start during DRAIN cancels the stop without disturbing the period.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check_bit("cancel_running", running, 1'b1);
    end
    measure_period("cancel_period", 5);

    // Start and stop together in IDLE: stop wins.
    stop = 1'b1;
    n = 0;
    while (running && n < 20) begin
      cyc();
      n++;
    end
    check_bit("reach_idle", running, 1'b0);
    start = 1'b1;
    cyc();
    check_bit("stop_wins", running, 1'b0);
    start = 1'b0;
    stop  = 1'b0;

    // Minimum divisor, then the maximum divisor.
    cfg_valid   = 1'b1;
    cfg_divisor = WIDTH'(2);
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    measure_period("min_div2", 2);
    cfg_valid   = 1'b1;
    cfg_divisor = {WIDTH{1'b1}};
    cyc();
    cfg_valid = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    repeat (10) cyc();
    check_bit("max_div_high", clock_out, 1'b1);

    // Clean reset, divisor 8, then asynchronous reset at position 2.
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock_in);
    reset = 1'b0;
    cfg_valid   = 1'b1;
    cfg_divisor = WIDTH'(8);
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check_bit("pre_reset_clk", clock_out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bit("async_clk", clock_out, 1'b0);
    check_bit("async_running", running, 1'b0);
    check_bit("async_tick", tick, 1'b0);
    check_bit("async_ready", cfg_ready, 1'b1);
    model_reset();
    @(negedge clock_in);
    reset = 1'b0;
    compare_all();
    start = 1'b1;
    cyc();
    start = 1'b0;
    measure_period("post_reset_default", 5);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cfg_valid   = ($urandom_range(0, 7) == 0);
      cfg_divisor = WIDTH'($urandom_range(0, 9));
      start       = ($urandom_range(0, 19) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
